// File: rtl/mul_pkg.sv
// Shared types and elaboration constants for the shift-add multiplier.
// Signed operation is enabled by defining SEQ_MULTIPLIER_SIGNED_EN.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int WIDTH_MIN     = 2;
  localparam int WIDTH_MAX     = 32;
  localparam int WIDTH_DEFAULT = 4;

  // The counter has to hold WIDTH itself, hence WIDTH+1 codes.
  localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT + 1);

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple adder/subtractor.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/ripple_add_sub.sv
// N-bit ripple-carry adder/subtractor: sub_i=1 computes a_i - b_i by
// inverting b_i and injecting a carry-in of one.
module ripple_add_sub #(
  parameter int N = 5
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N-1:0] b_x;
  logic [N:0]   carry;

  assign b_x      = b_i ^ {N{sub_i}};
  assign carry[0] = sub_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_x[i]),
      .c_i (carry[i]),
      .s_o (sum_o[i]),
      .c_o (carry[i+1])
    );
  end

  assign cout_o = carry[N];

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, one multiplier bit per clock, fixed WIDTH-cycle
// latency. Signed operands are honoured only when SEQ_MULTIPLIER_SIGNED_EN is defined.
import mul_pkg::*;

module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Product,
  output mul_state_e         dbg_state
);

  // Handshake: start is taken only while busy=0 (IDLE or DONE); operands are
  // captured on that edge, busy then stays high for WIDTH cycles and done
  // pulses for one cycle as Product is loaded. start while busy is ignored.

  localparam int              CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("seq_multiplier: WIDTH out of supported range");
  end

  mul_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic               signed_q, signed_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic start_signed;
  logic sub;
  logic last_step;

  assign last_step = (cnt_q == LAST);

`ifdef SEQ_MULTIPLIER_SIGNED_EN
  assign start_signed = is_signed;
  // The multiplier MSB carries weight -2^(WIDTH-1) in two's complement.
  assign sub          = signed_q & last_step;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign start_signed     = 1'b0;
  assign sub              = 1'b0;
`endif

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] add_b;
  logic [WIDTH:0] sum;
  logic           cout;
  logic [WIDTH:0] step_acc;
  logic [WIDTH-1:0] step_q;

  assign m_ext = signed_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
  assign add_b = q_q[0] ? m_ext : '0;

  ripple_add_sub #(
    .N (WIDTH + 1)
  ) u_add_sub (
    .a_i    (acc_q),
    .b_i    (add_b),
    .sub_i  (sub),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // {ACC,Q} >> 1: arithmetic when signed, carry-in from the adder otherwise.
  assign step_acc = {(signed_q ? sum[WIDTH] : cout), sum[WIDTH:1]};
  assign step_q   = {sum[0], q_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    signed_d  = signed_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d      = A;
          q_d      = B;
          signed_d = start_signed;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          product_d = {step_acc[WIDTH-1:0], step_q};
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      signed_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      signed_q  <= signed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Product   = product_q;
  assign dbg_state = state_q;

endmodule
